// File: rtl/encoder_scan_serializer.sv
// Accepts a WIDTH-bit request vector and emits the index of every set bit, one per beat.
// Optional feature: define ENCODER_SCAN_COUNT_EN to add out_total (popcount of the accepted vector).
module encoder_scan_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [IDX_W-1:0] out_index,
  output logic             out_none,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ENCODER_SCAN_COUNT_EN
  ,
  output logic [IDX_W:0]   out_total
`endif
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("encoder_scan_serializer: WIDTH must be in 2..64");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pending, pending_nx;
  logic             none_q, none_nx;
  logic [WIDTH-1:0] sel;
  logic [IDX_W-1:0] sel_idx;
  logic             single;

  // One-hot of the bit to emit next; the last match in loop order wins.
  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) begin
          r    = '0;
          r[i] = 1'b1;
        end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (v[i]) begin
          r    = '0;
          r[i] = 1'b1;
        end
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction

  assign sel     = pick(pending);
  assign sel_idx = encode(sel);
  // Exactly one bit left: the selected bit is the only one set.
  assign single  = (pending != '0) && ((pending & ~sel) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      none_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      none_q  <= none_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    none_nx    = none_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_index  = '0;
    out_none   = 1'b0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pending_nx = in_data;
          none_nx    = (in_data == '0);
          state_nx   = SCAN;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_index = sel_idx;
        out_none  = none_q;
        out_last  = single || none_q;
        if (out_ready) begin
          pending_nx = pending & ~sel;
          if (single || none_q) begin
            state_nx = IDLE;
            none_nx  = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // abort wins over both acceptance and a beat transfer in the same cycle.
    if (abort) begin
      state_nx   = IDLE;
      pending_nx = '0;
      none_nx    = 1'b0;
    end
  end

`ifdef ENCODER_SCAN_COUNT_EN
  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++)
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    return cnt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_total <= '0;
    else if (state == IDLE && in_valid && !abort)
      out_total <= popcount(in_data);
  end
`endif

endmodule

// File: tb/tb_encoder_scan_serializer.sv
// Scoreboard bench for encoder_scan_serializer: five instances of varied WIDTH/MSB_FIRST
// share one clock and data bus; a list-based reference model feeds per-instance queues.
module tb_encoder_scan_serializer;

  typedef struct {
    int idx;
    bit last;
    bit none;
    int total;
  } exp_t;

  localparam int W[5] = '{16, 8, 64, 5, 2};
  localparam bit M[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din;
  logic        ab;
  logic        iv[5], ir[5], ov[5], orr[5], ols[5], ons[5];
  logic        hold[5], rnd[5];
  logic [3:0]  idx0;
  logic [2:0]  idx1;
  logic [5:0]  idx2;
  logic [2:0]  idx3;
  logic [0:0]  idx4;
`ifdef ENCODER_SCAN_COUNT_EN
  logic [4:0]  tot0;
  logic [3:0]  tot1;
  logic [6:0]  tot2;
  logic [3:0]  tot3;
  logic [1:0]  tot4;
`endif

  exp_t exq[5][$];
  bit   stl[5];
  int   sidx[5];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  encoder_scan_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(din[15:0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .abort(ab), .out_index(idx0), .out_none(ons[0]), .out_last(ols[0]), .out_valid(ov[0]),
    .out_ready(orr[0])
`ifdef ENCODER_SCAN_COUNT_EN
    , .out_total(tot0)
`endif
  );
  encoder_scan_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(din[7:0]), .in_valid(iv[1]), .in_ready(ir[1]),
    .abort(1'b0), .out_index(idx1), .out_none(ons[1]), .out_last(ols[1]), .out_valid(ov[1]),
    .out_ready(orr[1])
`ifdef ENCODER_SCAN_COUNT_EN
    , .out_total(tot1)
`endif
  );
  encoder_scan_serializer #(.WIDTH(64), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(iv[2]), .in_ready(ir[2]),
    .abort(1'b0), .out_index(idx2), .out_none(ons[2]), .out_last(ols[2]), .out_valid(ov[2]),
    .out_ready(orr[2])
`ifdef ENCODER_SCAN_COUNT_EN
    , .out_total(tot2)
`endif
  );
  encoder_scan_serializer #(.WIDTH(5), .MSB_FIRST(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(din[4:0]), .in_valid(iv[3]), .in_ready(ir[3]),
    .abort(1'b0), .out_index(idx3), .out_none(ons[3]), .out_last(ols[3]), .out_valid(ov[3]),
    .out_ready(orr[3])
`ifdef ENCODER_SCAN_COUNT_EN
    , .out_total(tot3)
`endif
  );
  encoder_scan_serializer #(.WIDTH(2), .MSB_FIRST(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(din[1:0]), .in_valid(iv[4]), .in_ready(ir[4]),
    .abort(1'b0), .out_index(idx4), .out_none(ons[4]), .out_last(ols[4]), .out_valid(ov[4]),
    .out_ready(orr[4])
`ifdef ENCODER_SCAN_COUNT_EN
    , .out_total(tot4)
`endif
  );

  // Reference: list the set-bit positions in scan order; each becomes one beat.
  function automatic void model(input int d, input logic [63:0] vec);
    int   ids[$];
    exp_t e;
    for (int i = 0; i < W[d]; i++)
      if (vec[i]) ids.push_back(i);
    if (M[d]) ids.reverse();
    if (ids.size() == 0) begin
      e = '{idx: 0, last: 1'b1, none: 1'b1, total: 0};
      exq[d].push_back(e);
    end else begin
      foreach (ids[k]) begin
        e = '{idx: ids[k], last: (k == ids.size() - 1), none: 1'b0, total: ids.size()};
        exq[d].push_back(e);
      end
    end
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic observe(input int d, input logic v, input logic r, input int idx,
                         input logic last, input logic none, input int tot);
    exp_t e;
    if (stl[d] && v) begin
      n_tests++;
      if (idx != sidx[d]) begin
        n_fail++;
        $display("FAIL stall_hold dut%0d: index %0d, expected held %0d", d, idx, sidx[d]);
      end
    end
    stl[d]  = v && !r;
    sidx[d] = idx;
    if (v && r) begin
      n_tests++;
      if (exq[d].size() == 0) begin
        n_fail++;
        $display("FAIL beat dut%0d: unexpected beat index=%0d last=%0b none=%0b", d, idx, last, none);
      end else begin
        e = exq[d].pop_front();
        if (idx != e.idx || last != e.last || none != e.none || (tot >= 0 && tot != e.total)) begin
          n_fail++;
          $display("FAIL beat dut%0d: got idx=%0d last=%0b none=%0b total=%0d, expected idx=%0d last=%0b none=%0b total=%0d",
                   d, idx, last, none, tot, e.idx, e.last, e.none, e.total);
        end
      end
    end
  endtask

  // Monitor: samples every instance on the falling edge.
  initial begin
    int t[5];
    forever begin
      @(negedge clk);
      t = '{-1, -1, -1, -1, -1};
`ifdef ENCODER_SCAN_COUNT_EN
      t = '{int'(tot0), int'(tot1), int'(tot2), int'(tot3), int'(tot4)};
`endif
      if (rst_n) begin
        observe(0, ov[0], orr[0], int'(idx0), ols[0], ons[0], t[0]);
        observe(1, ov[1], orr[1], int'(idx1), ols[1], ons[1], t[1]);
        observe(2, ov[2], orr[2], int'(idx2), ols[2], ons[2], t[2]);
        observe(3, ov[3], orr[3], int'(idx3), ols[3], ons[3], t[3]);
        observe(4, ov[4], orr[4], int'(idx4), ols[4], ons[4], t[4]);
      end else begin
        for (int d = 0; d < 5; d++) stl[d] = 1'b0;
      end
    end
  end

  // out_ready driver: random or held per instance.
  initial begin
    for (int d = 0; d < 5; d++) orr[d] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 5; d++)
        orr[d] = rnd[d] ? ($urandom_range(0, 3) != 0) : hold[d];
    end
  end

  task automatic send(input int d, input logic [63:0] vec);
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    while (!ir[d] && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ir[d]) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout dut%0d: in_ready=%0b, required 1", d, ir[d]);
      return;
    end
    din   = vec;
    iv[d] = 1'b1;
    @(posedge clk);
    model(d, vec);
    #1 iv[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int guard;
    guard = 0;
    while ((exq[d].size() != 0 || !ir[d]) && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk($sformatf("drain_dut%0d_pending", d), exq[d].size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    din   = '0;
    ab    = 1'b0;
    for (int d = 0; d < 5; d++) begin
      iv[d]   = 1'b0;
      hold[d] = 1'b1;
      rnd[d]  = 1'b0;
    end
    #3;
    chk("reset_in_ready", ir[0], 1);
    chk("reset_out_valid", ov[0], 0);
    chk("reset_out_index", idx0, 0);
    chk("reset_out_last", ols[0], 0);
    chk("reset_out_none", ons[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // LSB-first pattern at full rate: 1,2,5,7 on consecutive cycles, then ready again.
    send(0, 64'h00A6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("lsb_seq_valid_%0d", k), ov[0], 1);
    end
    @(negedge clk);
    chk("lsb_seq_in_ready_after", ir[0], 1);
    chk("lsb_seq_valid_after", ov[0], 0);
    wait_idle(0);

    // MSB-first pattern with a stall while index 5 is presented.
    send(1, 64'hA6);
    @(posedge clk);
    #1 hold[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_idx_%0d", k), idx1, 5);
    end
    @(posedge clk);
    #1 hold[1] = 1'b1;
    wait_idle(1);

    // All-zero vector yields one none beat.
    send(1, 64'h0);
    @(negedge clk);
    chk("zero_none", ons[1], 1);
    chk("zero_last", ols[1], 1);
    wait_idle(1);

    // Abort on the second beat of 0xF: beats 0,1 delivered, 2,3 dropped.
    send(0, 64'hF);
    @(posedge clk);
    #1 ab = 1'b1;
    @(posedge clk);
    #1 ab = 1'b0;
    exq[0].delete();
    @(negedge clk);
    chk("abort_valid_after", ov[0], 0);
    chk("abort_in_ready_after", ir[0], 1);
    send(0, 64'h8);
    wait_idle(0);

    // Abort in IDLE blocks that cycle's accept.
    @(posedge clk);
    #1;
    din   = 64'h5;
    iv[0] = 1'b1;
    ab    = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    ab    = 1'b0;
    @(negedge clk);
    chk("idle_abort_no_accept", ov[0], 0);

    // Asynchronous reset mid-scan after 5 beats.
    send(0, 64'hFFFF);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_valid", ov[0], 0);
    chk("midreset_index", idx0, 0);
    chk("midreset_last", ols[0], 0);
    chk("midreset_in_ready", ir[0], 1);
    exq[0].delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 64'h1);
    wait_idle(0);

    // All-ones scans on the narrow and wide instances.
    send(2, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle(2);
    send(3, 64'h1F);
    wait_idle(3);
    send(4, 64'h3);
    wait_idle(4);

    // Randomized vectors with random backpressure.
    for (int d = 0; d < 5; d++) rnd[d] = 1'b1;
    for (int d = 0; d < 5; d++) begin
      for (int n = 0; n < 25; n++) begin
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        if ($urandom_range(0, 7) == 0) v = '0;
        else if ($urandom_range(0, 3) == 0) v = v & {$urandom(), $urandom()};
        send(d, v);
      end
      wait_idle(d);
    end
    for (int d = 0; d < 5; d++) rnd[d] = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
